// File: rtl/branch_unit_if.sv
// Request, redirect and statistics signals shared between a branch_unit and its issuer.
// The master side issues branch/jump requests and acknowledges redirects.
interface branch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        op;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [15:0]       imm;
  logic [25:0]       jimm;
  logic              slot_done;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_ack;
  logic              align_err;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  tk_cnt;

  modport master (
    output req_valid, op, pc, rs_val, rt_val, imm, jimm, slot_done, redir_ack,
    input  req_ready, redir_valid, redir_pc, align_err, br_cnt, tk_cnt
  );

  modport slave (
    input  req_valid, op, pc, rs_val, rt_val, imm, jimm, slot_done, redir_ack,
    output req_ready, redir_valid, redir_pc, align_err, br_cnt, tk_cnt
  );
endinterface

// File: rtl/branch_unit.sv
// MIPS-style branch/jump resolver: captures a request, resolves it in one cycle,
// optionally waits for the delay slot, then holds a redirect until fetch accepts it.
module branch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_unit_if.slave bus
);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLEZ = 3'd2;
  localparam logic [2:0] OP_BGTZ = 3'd3;
  localparam logic [2:0] OP_BLTZ = 3'd4;
  localparam logic [2:0] OP_BGEZ = 3'd5;
  localparam logic [2:0] OP_J    = 3'd6;
  localparam logic [2:0] OP_JR   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_WAIT_SLOT,
    S_REDIRECT
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rt;
  logic [15:0]       r_imm;
  logic [25:0]       r_jimm;
  logic              r_slot_flag;
  logic [ADDR_W-1:0] r_redir_pc;
  logic              r_align_err;
  logic [CNT_W-1:0]  r_br_cnt;
  logic [CNT_W-1:0]  r_tk_cnt;

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_j_target;
  logic [ADDR_W-1:0] w_target;
  logic              w_rs_neg;
  logic              w_rs_zero;
  logic              w_taken;
  logic              w_misaligned;
  logic              w_redirect;
  logic              w_accept;

  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_pc4     = r_pc + ADDR_W'(4);
  assign w_br_off  = {{(ADDR_W-18){r_imm[15]}}, r_imm, 2'b00};
  assign w_rs_neg  = r_rs[DATA_W-1];
  assign w_rs_zero = (r_rs == '0);

  // J keeps the upper region bits of pc+4; with a 28-bit PC there are none.
  if (ADDR_W > 28) begin : g_j_region
    assign w_j_target = {w_pc4[ADDR_W-1:28], r_jimm, 2'b00};
  end else begin : g_j_flat
    assign w_j_target = {r_jimm, 2'b00};
  end

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc4 + w_br_off;
    case (r_op)
      OP_BEQ:  w_taken = (r_rs == r_rt);
      OP_BNE:  w_taken = (r_rs != r_rt);
      OP_BLEZ: w_taken = w_rs_neg || w_rs_zero;
      OP_BGTZ: w_taken = !w_rs_neg && !w_rs_zero;
      OP_BLTZ: w_taken = w_rs_neg;
      OP_BGEZ: w_taken = !w_rs_neg;
      OP_J: begin
        w_taken  = 1'b1;
        w_target = w_j_target;
      end
      OP_JR: begin
        w_taken  = 1'b1;
        w_target = r_rs[ADDR_W-1:0];
      end
      default: w_taken = 1'b0;
    endcase
  end

  assign w_misaligned = (r_op == OP_JR) && (r_rs[1:0] != 2'b00);
  assign w_redirect   = w_taken && !w_misaligned;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) w_state_next = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (!w_redirect)          w_state_next = S_IDLE;
        else if (DELAY_SLOT != 0) w_state_next = S_WAIT_SLOT;
        else                      w_state_next = S_REDIRECT;
      end
      S_WAIT_SLOT: begin
        if (bus.slot_done || r_slot_flag) w_state_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (bus.redir_ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_pc        <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_imm       <= '0;
      r_jimm      <= '0;
      r_slot_flag <= 1'b0;
      r_redir_pc  <= '0;
      r_align_err <= 1'b0;
      r_br_cnt    <= '0;
      r_tk_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_align_err <= (r_state == S_RESOLVE) && w_misaligned;

      if (w_accept) begin
        r_op   <= bus.op;
        r_pc   <= bus.pc;
        r_rs   <= bus.rs_val;
        r_rt   <= bus.rt_val;
        r_imm  <= bus.imm;
        r_jimm <= bus.jimm;
      end

      if (r_state == S_RESOLVE) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
        if (w_redirect) begin
          r_tk_cnt   <= r_tk_cnt + CNT_W'(1);
          r_redir_pc <= w_target;
        end
      end

      // An early slot_done must survive the hop into WAIT_SLOT.
      if (w_state_next == S_IDLE)
        r_slot_flag <= 1'b0;
      else if ((r_state == S_RESOLVE) && bus.slot_done)
        r_slot_flag <= 1'b1;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.redir_valid = (r_state == S_REDIRECT);
  assign bus.redir_pc    = r_redir_pc;
  assign bus.align_err   = r_align_err;
  assign bus.br_cnt      = r_br_cnt;
  assign bus.tk_cnt      = r_tk_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a driver pushes expected outcomes from a
// behavioural model, a monitor pops them as resolutions and redirects appear.
module tb_branch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_unit_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bif  ();
  branch_unit_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bif0 ();

  branch_unit #(.ADDR_W(32), .DATA_W(32), .DELAY_SLOT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );
  branch_unit #(.ADDR_W(32), .DATA_W(32), .DELAY_SLOT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bif0)
  );

  typedef struct {
    logic        redirect;
    logic        align;
    logic [31:0] target;
    logic [15:0] br;
    logic [15:0] tk;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_br = '0;
  logic [15:0] m_tk = '0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: outcome of a request straight from the instruction semantics.
  task automatic model(input logic [2:0] op, input logic [31:0] pc, rs, rt,
                       input logic [15:0] imm, input logic [25:0] jimm,
                       output logic redirect, output logic align, output logic [31:0] target);
    int srs;
    int off;
    logic taken;
    srs = int'(rs);
    off = int'($signed(imm)) * 4;
    taken = 1'b0;
    target = pc + 32'd4 + 32'(off);
    case (op)
      3'd0: taken = (rs == rt);
      3'd1: taken = (rs != rt);
      3'd2: taken = (srs <= 0);
      3'd3: taken = (srs > 0);
      3'd4: taken = (srs < 0);
      3'd5: taken = (srs >= 0);
      3'd6: begin
        taken = 1'b1;
        target = ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, jimm} << 2);
      end
      default: begin
        taken = 1'b1;
        target = rs;
      end
    endcase
    align = (op == 3'd7) && ((rs % 4) != 0);
    redirect = taken && !align;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] pc, rs, rt,
                       input logic [15:0] imm, input logic [25:0] jimm,
                       input int slot_dly, input int ack_dly);
    exp_t e;
    int ack_cnt;
    for (int i = 0; i < 20 && !bif.req_ready; i++) @(negedge clk);
    chk("ready_timeout", 64'(bif.req_ready), 64'd1);
    model(op, pc, rs, rt, imm, jimm, e.redirect, e.align, e.target);
    m_br = m_br + 16'd1;
    if (e.redirect) m_tk = m_tk + 16'd1;
    e.br = m_br;
    e.tk = m_tk;
    e.lat = (slot_dly < 1) ? 1 : slot_dly;
    sb_q.push_back(e);
    bif.req_valid = 1'b1;
    bif.op = op; bif.pc = pc; bif.rs_val = rs; bif.rt_val = rt;
    bif.imm = imm; bif.jimm = jimm;
    @(posedge clk);
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.op = 3'($urandom); bif.pc = $urandom; bif.rs_val = $urandom;
    bif.rt_val = $urandom; bif.imm = 16'($urandom); bif.jimm = 26'($urandom);
    for (int k = 0; k <= slot_dly; k++) begin
      bif.slot_done = (k == slot_dly);
      @(negedge clk);
    end
    bif.slot_done = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 40 && !bif.req_ready; i++) begin
      if (bif.redir_valid) begin
        bif.redir_ack = (ack_cnt == ack_dly);
        ack_cnt++;
      end
      @(negedge clk);
    end
    bif.redir_ack = 1'b0;
    chk("done_timeout", 64'(bif.req_ready), 64'd1);
  endtask

  // Monitor: a br_cnt step marks the cycle after RESOLVE.
  logic [15:0] last_br = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_pc = '0;
  int          pend_lat = 0;
  int          exp_lat = 0;
  logic        rv_seen = 1'b0;
  logic        prev_rv = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bif.br_cnt != last_br) begin
        last_br = bif.br_cnt;
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          $display("resolve: br=%0d tk=%0d align=%0b redirect=%0b target=0x%08h",
                   bif.br_cnt, bif.tk_cnt, bif.align_err, e.redirect, e.target);
          chk("br_cnt", 64'(bif.br_cnt), 64'(e.br));
          chk("tk_cnt", 64'(bif.tk_cnt), 64'(e.tk));
          chk("align_err", 64'(bif.align_err), 64'(e.align));
          chk("redir_after_resolve", 64'(bif.redir_valid), 64'd0);
          if (e.redirect) begin
            pend = 1'b1;
            pend_pc = e.target;
            exp_lat = e.lat;
            pend_lat = 0;
            rv_seen = 1'b0;
          end else begin
            chk("idle_after_notaken", 64'(bif.req_ready), 64'd1);
          end
        end
      end else begin
        chk("align_err_quiet", 64'(bif.align_err), 64'd0);
        if (pend && !rv_seen) pend_lat++;
      end
      if (bif.redir_valid) begin
        chk("spurious_redirect", 64'(bif.redir_valid), 64'(pend));
        if (pend) begin
          if (!rv_seen) begin
            chk("redirect_latency", 64'(pend_lat), 64'(exp_lat));
            rv_seen = 1'b1;
          end
          chk("redir_pc", 64'(bif.redir_pc), 64'(pend_pc));
          chk("ready_in_redirect", 64'(bif.req_ready), 64'd0);
        end
      end
      if (!bif.redir_valid && prev_rv) pend = 1'b0;
      prev_rv = bif.redir_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  op;
    {bif.req_valid, bif.op, bif.pc, bif.rs_val, bif.rt_val} = '0;
    {bif.imm, bif.jimm, bif.slot_done, bif.redir_ack} = '0;
    {bif0.req_valid, bif0.op, bif0.pc, bif0.rs_val, bif0.rt_val} = '0;
    {bif0.imm, bif0.jimm, bif0.slot_done, bif0.redir_ack} = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_redir_valid", 64'(bif.redir_valid), 64'd0);
    chk("rst_redir_pc", 64'(bif.redir_pc), 64'd0);
    chk("rst_align_err", 64'(bif.align_err), 64'd0);
    chk("rst_br_cnt", 64'(bif.br_cnt), 64'd0);
    chk("rst_tk_cnt", 64'(bif.tk_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bif.req_ready), 64'd1);
    mon_en = 1'b1;

    issue(3'd0, 32'h0040_0010, 32'd5, 32'd5, 16'hFFFC, 26'd0, 2, 1);
    issue(3'd3, 32'h0040_0020, 32'h8000_0000, 32'd0, 16'h0010, 26'd0, 1, 0);
    issue(3'd7, 32'h0040_0030, 32'h0040_0002, 32'd0, 16'd0, 26'd0, 0, 0);
    issue(3'd7, 32'h0040_0040, 32'h0040_0008, 32'd0, 16'd0, 26'd0, 1, 2);
    issue(3'd0, 32'hFFFF_FFF8, 32'd9, 32'd9, 16'h0001, 26'd0, 0, 0);
    issue(3'd2, 32'h0000_1000, 32'd0, 32'd1, 16'h0008, 26'd0, 3, 3);
    issue(3'd6, 32'h1000_0000, 32'd0, 32'd0, 16'd0, 26'h0000100, 1, 1);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = $urandom;
        2: rs = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rs = 32'($urandom_range(1, 8));
      endcase
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      op = 3'($urandom);
      issue(op, $urandom, rs, rt, 16'($urandom), 26'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Immediate-redirect instance: J held through three cycles without ack.
    bif0.req_valid = 1'b1;
    bif0.op = 3'd6; bif0.pc = 32'h1000_0000; bif0.jimm = 26'h0000100;
    @(posedge clk);
    @(negedge clk);
    bif0.req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ds0_redir_valid", 64'(bif0.redir_valid), 64'd1);
      chk("ds0_redir_pc", 64'(bif0.redir_pc), 64'h1000_0400);
      $display("ds0 redirect hold %0d: valid=%0b pc=0x%08h", i, bif0.redir_valid, bif0.redir_pc);
      @(negedge clk);
    end
    bif0.redir_ack = 1'b1;
    @(negedge clk);
    bif0.redir_ack = 1'b0;
    chk("ds0_idle_after_ack", 64'(bif0.req_ready), 64'd1);
    chk("ds0_valid_after_ack", 64'(bif0.redir_valid), 64'd0);
    chk("ds0_tk_cnt", 64'(bif0.tk_cnt), 64'd1);

    // Reset while a redirect is being acknowledged.
    mon_en = 1'b0;
    bif.req_valid = 1'b1;
    bif.op = 3'd0; bif.pc = 32'h0000_2000; bif.rs_val = 32'd3; bif.rt_val = 32'd3;
    bif.imm = 16'd4;
    @(posedge clk);
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.slot_done = 1'b1;
    @(negedge clk);
    bif.slot_done = 1'b0;
    for (int i = 0; i < 10 && !bif.redir_valid; i++) @(negedge clk);
    chk("pre_reset_redirect", 64'(bif.redir_valid), 64'd1);
    bif.redir_ack = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    bif.redir_ack = 1'b0;
    $display("reset in redirect: valid=%0b br=%0d tk=%0d", bif.redir_valid, bif.br_cnt, bif.tk_cnt);
    chk("rst_redir_valid2", 64'(bif.redir_valid), 64'd0);
    chk("rst_br_cnt2", 64'(bif.br_cnt), 64'd0);
    chk("rst_tk_cnt2", 64'(bif.tk_cnt), 64'd0);
    chk("rst_redir_pc2", 64'(bif.redir_pc), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(bif.req_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
